ps2_scan_ctrl: RTL

Sequencer between the ps2_kbd receiver and the CPU bus. It pops raw scan bytes from ps2_kbd using the ready/rdn handshake and folds the E0 (extended) and F0 (break) prefixes into single key events. Events are buffered in a small FIFO, which the CPU reads through a registered slave port with interrupt and acknowledge. It replaces direct byte-at-a-time polling of ps2_kbd.

---
 rtl/ps2_scan_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ps2_scan_ctrl.sv
// Scan-code sequencer: pops raw bytes from ps2_kbd, folds E0/F0 prefixes into
// key events, buffers them in a FIFO and exposes them on a registered slave port.
module ps2_scan_ctrl #(
  parameter int FIFO_AW = 3
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_ready,
  input  logic        kbd_overflow,
  output logic        kbd_rdn,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        irq,
  input  logic        iack
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, POP, WAIT} state_t;
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  state_t             state;
  logic               ext, brk, ovf;
  logic               ctrl_en, ctrl_irq_en;
  evt_t               mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   count;
  logic               empty, full;
  logic               acc, push, pop;
  logic [1:0]         reg_sel;
  logic [31:0]        rdata;

  assign empty   = (count == '0);
  assign full    = (count == (FIFO_AW+1)'(DEPTH));
  assign acc     = stb_i & ~ack_o;
  assign reg_sel = adr_i[3:2];
  assign push    = (state == POP) && (kbd_data != PFX_EXT) && (kbd_data != PFX_BRK);
  assign pop     = acc & ~we_i & (reg_sel == 2'd0) & ~empty;
  assign irq     = ctrl_irq_en & ~empty & ~iack;

  // kbd_rdn is low only while in POP; full FIFO holds the FSM in IDLE.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= IDLE;
      kbd_rdn <= 1'b1;
      ext     <= 1'b0;
      brk     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ctrl_en && kbd_ready && !full) begin
          state   <= POP;
          kbd_rdn <= 1'b0;
        end
        POP: begin
          state   <= WAIT;
          kbd_rdn <= 1'b1;
          if (kbd_data == PFX_EXT)      ext <= 1'b1;
          else if (kbd_data == PFX_BRK) brk <= 1'b1;
          else begin
            ext <= 1'b0;
            brk <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          kbd_rdn <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{ext: ext, brk: brk, code: kbd_data};
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0: if (!empty) rdata[10:0] = {1'b1, mem[rptr]};
      2'd1: begin
        rdata[0]              = ~empty;
        rdata[1]              = full;
        rdata[2]              = ovf;
        rdata[3]              = ext;
        rdata[4]              = brk;
        rdata[8 +: FIFO_AW+1] = count;
      end
      2'd2: rdata[1:0] = {ctrl_irq_en, ctrl_en};
      default: rdata = '0;
    endcase
  end

  // A live overflow outranks a same-cycle W1C clear.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ack_o       <= 1'b0;
      dat_o       <= '0;
      ovf         <= 1'b0;
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
    end else begin
      ack_o <= acc;
      if (acc) dat_o <= rdata;
      if (kbd_overflow)
        ovf <= 1'b1;
      else if (acc && we_i && reg_sel == 2'd1 && dat_i[2])
        ovf <= 1'b0;
      if (acc && we_i && reg_sel == 2'd2) begin
        ctrl_en     <= dat_i[0];
        ctrl_irq_en <= dat_i[1];
      end
    end
  end

endmodule
